// File: rtl/lc3b_types.sv
// Shared types for the 4-way cache controller slice.
// Holds the controller state encoding and the way-index type.
// Also provides the hit-vector priority encoder used by the controller.
package lc3b_types;

  typedef logic [1:0] lc3b_c_way;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } cache_ctrl_state_t;

  // Index of the lowest set bit of a 4-way hit vector (0 when none set).
  function automatic lc3b_c_way lowest_hit(input logic [3:0] h);
    lc3b_c_way w;
    w = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (h[i]) w = lc3b_c_way'(i);
    end
    return w;
  endfunction

endpackage

// File: rtl/cache_ctrl_4way_pmem_watchdog.sv
// Counts cycles spent waiting on physical memory and flags a timeout.
// expired is combinational: high during the PMEM_TIMEOUT-th cycle of a run.
// No backpressure; clear has priority over run.
module pmem_watchdog #(
  parameter int PMEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(PMEM_TIMEOUT + 1);

  logic [CW-1:0] count;

  // The count holds the number of completed cycles in the current state,
  // so the cycle in which it equals PMEM_TIMEOUT-1 is the last one allowed.
  assign expired = run && (count == CW'(PMEM_TIMEOUT - 1));

  // Clear on reset or state entry; otherwise count while running, saturating.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (run && !expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/cache_ctrl_4way.sv
// Control FSM for a 4-way write-back cache: hit service, victim writeback, refill.
// Hits complete in the request cycle; misses take writeback + refill, then hit.
// Waits on pmem_resp in WRITEBACK/ALLOCATE, bounded by a watchdog timeout.
module cache_ctrl_4way
  import lc3b_types::*;
#(
  parameter int PMEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mem_read,
  input  logic       mem_write,
  output logic       mem_resp,
  input  logic [3:0] hit,
  input  logic       victim_dirty,
  input  logic [1:0] plru_way,
  output logic       plru_update,
  output logic [1:0] way_sel,
  output logic       load_data,
  output logic       data_src,
  output logic       load_tag,
  output logic       set_dirty,
  output logic       pmem_addr_sel,
  output logic       pmem_read,
  output logic       pmem_write,
  input  logic       pmem_resp,
  output logic       pmem_err
);

  cache_ctrl_state_t state, state_next;
  lc3b_c_way         victim;
  logic              req;
  logic              is_write;
  logic              err_set;
  logic              wd_clear;
  logic              wd_run;
  logic              wd_expired;

  assign req      = mem_read || mem_write;
  assign is_write = mem_write;  // read+write together is treated as a write

  // The watchdog restarts on every state change and runs only while waiting on pmem.
  assign wd_clear = (state_next != state);
  assign wd_run   = (state == WRITEBACK) || (state == ALLOCATE);

  pmem_watchdog #(
    .PMEM_TIMEOUT(PMEM_TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .run    (wd_run),
    .expired(wd_expired)
  );

  // Datapath controls and next state, decoded from the current state and inputs.
  always_comb begin
    state_next    = state;
    err_set       = 1'b0;
    mem_resp      = 1'b0;
    plru_update   = 1'b0;
    way_sel       = victim;
    load_data     = 1'b0;
    data_src      = 1'b0;
    load_tag      = 1'b0;
    set_dirty     = 1'b0;
    pmem_addr_sel = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (hit != 4'b0) begin
            mem_resp    = 1'b1;
            plru_update = 1'b1;
            way_sel     = lowest_hit(hit);
            if (is_write) begin
              load_data = 1'b1;
              set_dirty = 1'b1;
            end
          end else begin
            // Point the datapath at the candidate victim so victim_dirty is its dirty bit.
            way_sel    = plru_way;
            state_next = victim_dirty ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
        if (pmem_resp) begin
          state_next = ALLOCATE;
        end else if (wd_expired) begin
          state_next = IDLE;
          err_set    = 1'b1;
        end
      end
      ALLOCATE: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          load_data  = 1'b1;
          data_src   = 1'b1;
          load_tag   = 1'b1;
          state_next = IDLE;
        end else if (wd_expired) begin
          state_next = IDLE;
          err_set    = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, victim way (captured on a miss) and the sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      victim   <= 2'd0;
      pmem_err <= 1'b0;
    end else begin
      state <= state_next;
      if ((state == IDLE) && req && (hit == 4'b0)) begin
        victim <= plru_way;
      end
      if (err_set) begin
        pmem_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cache_ctrl_4way.sv
// Randomized self-checking bench for cache_ctrl_4way.
// Expected outputs are derived per transaction from the controller's rules.
// Short watchdog timeout so timeouts are reachable in random runs.
module tb_cache_ctrl_4way;

  localparam int T = 8;

  logic       clk;
  logic       rst;
  logic       mem_read;
  logic       mem_write;
  logic       mem_resp;
  logic [3:0] hit;
  logic       victim_dirty;
  logic [1:0] plru_way;
  logic       plru_update;
  logic [1:0] way_sel;
  logic       load_data;
  logic       data_src;
  logic       load_tag;
  logic       set_dirty;
  logic       pmem_addr_sel;
  logic       pmem_read;
  logic       pmem_write;
  logic       pmem_resp;
  logic       pmem_err;

  int total = 0;
  int bad   = 0;

  // Reference state: sticky error flag and the way remembered from the last miss.
  logic       m_err;
  logic [1:0] m_victim;

  logic [11:0] obs;
  assign obs = {mem_resp, plru_update, way_sel, load_data, data_src, load_tag,
                set_dirty, pmem_addr_sel, pmem_read, pmem_write, pmem_err};

  cache_ctrl_4way #(.PMEM_TIMEOUT(T)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_resp     (mem_resp),
    .hit          (hit),
    .victim_dirty (victim_dirty),
    .plru_way     (plru_way),
    .plru_update  (plru_update),
    .way_sel      (way_sel),
    .load_data    (load_data),
    .data_src     (data_src),
    .load_tag     (load_tag),
    .set_dirty    (set_dirty),
    .pmem_addr_sel(pmem_addr_sel),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_resp    (pmem_resp),
    .pmem_err     (pmem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b (resp,upd,way,ld,src,ltag,sdirty,asel,rd,wr,err)",
               tag, got, exp);
    end
  endtask

  function automatic logic [11:0] mk(input logic resp, input logic upd, input logic [1:0] way,
                                     input logic ld, input logic src, input logic ltag,
                                     input logic sd, input logic asel, input logic rd,
                                     input logic wr, input logic err);
    return {resp, upd, way, ld, src, ltag, sd, asel, rd, wr, err};
  endfunction

  // Inputs are already set; compare mid-cycle, then advance past the next edge.
  task automatic step(input string tag, input logic [11:0] exp);
    @(negedge clk);
    chk(tag, obs, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle(input string tag);
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    hit          = 4'($urandom);
    plru_way     = 2'($urandom);
    victim_dirty = 1'($urandom);
    pmem_resp    = 1'($urandom);
    step(tag, mk(0, 0, m_victim, 0, 0, 0, 0, 0, 0, 0, m_err));
  endtask

  // kind: 0 read, 1 write, 2 read+write (behaves as write)
  task automatic hit_cycle(input string tag, input int kind, input logic [3:0] h);
    logic [1:0] w;
    logic       found;
    logic       wr;
    found = 1'b0;
    w     = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (h[i] && !found) begin
        w     = 2'(i);
        found = 1'b1;
      end
    end
    wr           = (kind != 0);
    mem_read     = (kind != 1);
    mem_write    = wr;
    hit          = h;
    plru_way     = 2'($urandom);
    victim_dirty = 1'($urandom);
    pmem_resp    = 1'($urandom);
    step(tag, mk(1, 1, w, wr, 0, 0, wr, 0, 0, 0, m_err));
  endtask

  // A full miss. lat_* is the cycle (1-based) of pmem_resp in that state; above T means
  // it never arrives. drop_at > 0 deasserts the request from that ALLOCATE cycle on.
  task automatic miss(input logic wr, input logic [1:0] pw, input logic dirty,
                      input int lat_wb, input int lat_al, input int drop_at);
    logic aborted;
    logic dropped;
    logic resp;
    aborted      = 1'b0;
    dropped      = 1'b0;
    mem_write    = wr;
    mem_read     = wr ? 1'($urandom) : 1'b1;
    hit          = 4'b0;
    plru_way     = pw;
    victim_dirty = dirty;
    pmem_resp    = 1'b0;
    step("miss_idle", mk(0, 0, pw, 0, 0, 0, 0, 0, 0, 0, m_err));
    m_victim = pw;
    if (dirty) begin
      for (int c = 1; c <= T; c++) begin
        plru_way     = 2'($urandom);
        victim_dirty = 1'($urandom);
        pmem_resp    = (c == lat_wb);
        step("writeback", mk(0, 0, pw, 0, 0, 0, 0, 1, 0, 1, m_err));
        if (c == lat_wb) break;
        if (c == T) begin
          aborted = 1'b1;
          m_err   = 1'b1;
        end
      end
    end
    if (!aborted) begin
      for (int c = 1; c <= T; c++) begin
        if (drop_at > 0 && c >= drop_at) begin
          mem_read  = 1'b0;
          mem_write = 1'b0;
          dropped   = 1'b1;
        end
        plru_way     = 2'($urandom);
        victim_dirty = 1'($urandom);
        resp         = (c == lat_al);
        pmem_resp    = resp;
        step("allocate", mk(0, 0, pw, resp, resp, resp, 0, 0, 1, 0, m_err));
        if (resp) break;
        if (c == T) begin
          aborted = 1'b1;
          m_err   = 1'b1;
        end
      end
    end
    if (!aborted && !dropped) begin
      hit_cycle("refill_hit", wr ? 1 : 0, 4'(1 << pw));
    end else begin
      idle_cycle(aborted ? "after_timeout" : "after_drop");
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    pmem_resp = 1'b0;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    m_err    = 1'b0;
    m_victim = 2'd0;
  endtask

  initial begin
    rst          = 1'b1;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    hit          = 4'b0;
    victim_dirty = 1'b0;
    plru_way     = 2'd0;
    pmem_resp    = 1'b0;
    m_err        = 1'b0;
    m_victim     = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycle("reset_state");

    // Directed cases.
    hit_cycle("read_hit_0100", 0, 4'b0100);
    hit_cycle("write_hit_0001", 1, 4'b0001);
    hit_cycle("rw_hit_1010", 2, 4'b1010);
    miss(1'b0, 2'd3, 1'b1, 5, 5, 0);
    idle_cycle("post_dirty_miss");
    miss(1'b1, 2'd1, 1'b0, 99, T, 0);       // response coincides with the timeout cycle
    idle_cycle("resp_at_timeout");
    miss(1'b0, 2'd2, 1'b0, 99, 4, 2);       // request dropped mid-refill
    miss(1'b0, 2'd2, 1'b0, 99, 99, 0);      // refill times out
    hit_cycle("err_sticky_hit", 0, 4'b1000);
    idle_cycle("err_sticky_idle");

    // Reset in the third writeback cycle.
    do_reset();
    idle_cycle("reset_clears_err");
    mem_read     = 1'b1;
    mem_write    = 1'b0;
    hit          = 4'b0;
    plru_way     = 2'd1;
    victim_dirty = 1'b1;
    pmem_resp    = 1'b0;
    step("rst_miss_idle", mk(0, 0, 2'd1, 0, 0, 0, 0, 0, 0, 0, 0));
    m_victim = 2'd1;
    step("rst_wb1", mk(0, 0, 2'd1, 0, 0, 0, 0, 1, 0, 1, 0));
    step("rst_wb2", mk(0, 0, 2'd1, 0, 0, 0, 0, 1, 0, 1, 0));
    rst = 1'b1;
    step("rst_wb3", mk(0, 0, 2'd1, 0, 0, 0, 0, 1, 0, 1, 0));
    rst       = 1'b0;
    mem_read  = 1'b0;
    m_victim  = 2'd0;
    m_err     = 1'b0;
    step("rst_outputs_zero", mk(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0));
    hit_cycle("rst_then_hit_0010", 0, 4'b0010);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 4) begin
        hit_cycle("rand_hit", $urandom_range(0, 2), 4'($urandom_range(1, 15)));
      end else if (sel < 8) begin
        miss(1'($urandom), 2'($urandom), 1'($urandom), $urandom_range(1, T + 2),
             $urandom_range(1, T + 2), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0);
      end else if (sel < 9) begin
        idle_cycle("rand_idle");
      end else begin
        do_reset();
        idle_cycle("rand_reset");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
